leaf_binop_pipe: RTL and testbench
==================================

LEAF_BINOP_PIPE -- requirements
Module: leaf_binop_pipe

Interface
REQ-001 Parameter STREAMW, default 32, operand and result width in bits (legal range 8..64).
REQ-002 Parameter LATENCY, default 3, pipeline stages from operand acceptance to result presentation (legal range 1..8).
REQ-003 Parameter OPCODE, default 1, datapath operation: 0 = add, 1 = subtract (in1 - in2), 2 = multiply (low STREAMW bits).
REQ-004 clk  input  1  single clock for all state; rising-edge active.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in1  input  STREAMW  first operand.
REQ-007 ivalid_in1  input  1  in1 valid.
REQ-008 iready_in1  output  1  in1 consumed this cycle.
REQ-009 in2  input  STREAMW  second operand.
REQ-010 ivalid_in2  input  1  in2 valid.
REQ-011 iready_in2  output  1  in2 consumed this cycle.
REQ-012 out1  output  STREAMW  result.
REQ-013 ovalid  output  1  out1 valid.
REQ-014 oready  input  1  downstream can accept out1.
REQ-015 occupancy  output  4  number of valid results currently held in the pipeline (0..LATENCY).

Function
REQ-016 The block SHALL hold LATENCY stages, each with a data register and a valid bit; stage LATENCY-1 drives out1/ovalid directly from registers.
REQ-017 A transfer out SHALL occur on any cycle with ovalid=1 and oready=1.
REQ-018 Stage k SHALL load from stage k-1 when stage k is empty or stage k is itself advancing this cycle (bubble collapsing); otherwise it SHALL hold.
REQ-019 An input join SHALL fire only when ivalid_in1=1, ivalid_in2=1 and stage 0 can load per REQ-018.
REQ-020 iready_in1 and iready_in2 SHALL both equal the join-fire condition, so neither operand is ever consumed alone.
REQ-021 On join fire, stage 0 SHALL capture the OPCODE result computed combinationally from in1/in2, with valid set.
REQ-022 A stage that passes its data downstream without reloading SHALL clear its valid bit.
REQ-023 Arithmetic SHALL be two's-complement modulo 2^STREAMW; overflow wraps silently, no flags.
REQ-024 With oready held high and operands always valid, throughput SHALL be one result per cycle and out1 SHALL appear exactly LATENCY cycles after join fire.
REQ-025 With oready low, the pipeline SHALL keep accepting operands until all LATENCY stages are valid, then deassert iready_in1/iready_in2.
REQ-026 When full and oready rises, a new operand pair SHALL be accepted in the same cycle as the output transfer (no dead cycle).
REQ-027 out1 SHALL be stable while ovalid=1 and oready=0.
REQ-028 occupancy SHALL increment on join fire without output transfer, decrement on output transfer without join fire, and be unchanged when both or neither occur.
REQ-029 Combinational paths SHALL be limited to operands -> stage 0 and oready/ivalid -> iready; no path from oready to ovalid or out1.

Reset
REQ-030 While rst=1 all stage valid bits, ovalid, iready_in1, iready_in2 and occupancy SHALL be 0 immediately, independent of clk.
REQ-031 Data registers SHALL reset to 0, so out1=0 during and after reset until the first result.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight results; no result from before reset SHALL appear afterwards.
REQ-033 First join fire SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 LATENCY=3, OPCODE=1, oready=1, pairs (10,3),(0,1),(5,5) on consecutive cycles -> out1 = 7, 0xFFFFFFFF, 0 on cycles 3,4,5 after first fire, ovalid high for those 3 cycles only.
REQ-035 LATENCY=3, oready=0, 5 pairs offered back-to-back -> exactly 3 accepted, occupancy=3, iready low; raise oready -> results drain in order, remaining 2 pairs accepted with no dead cycle.
REQ-036 ivalid_in1=1 for 4 cycles, ivalid_in2=0 -> iready_in1 stays 0, occupancy stays 0; ivalid_in2 rises -> single join fire.
REQ-037 Random ivalid/oready toggling, 1000 pairs, OPCODE 0/1/2, LATENCY 1 and 8 -> scoreboard matches every result in order, none lost or duplicated; out1 stable while stalled.
REQ-038 rst pulsed asynchronously (mid-cycle) with occupancy=2 -> ovalid, occupancy drop to 0 before next edge; no stale result after release.
REQ-039 OPCODE=2, STREAMW=8, pair (200,3) -> out1 = 0x58 (600 mod 256).

Source files
------------

// File: rtl/leaf_binop_pipe_if.sv
// Operand/result stream bundle for leaf_binop_pipe.
// Two joined operand streams in, one result stream out.
interface leaf_binop_pipe_if #(
  parameter int STREAMW = 32
);
  logic [STREAMW-1:0] in1;
  logic               ivalid_in1;
  logic               iready_in1;
  logic [STREAMW-1:0] in2;
  logic               ivalid_in2;
  logic               iready_in2;
  logic [STREAMW-1:0] out1;
  logic               ovalid;
  logic               oready;
  logic [3:0]         occupancy;

  modport master (
    output in1, ivalid_in1, in2, ivalid_in2, oready,
    input  iready_in1, iready_in2, out1, ovalid, occupancy
  );

  modport slave (
    input  in1, ivalid_in1, in2, ivalid_in2, oready,
    output iready_in1, iready_in2, out1, ovalid, occupancy
  );
endinterface

// File: rtl/leaf_binop_pipe.sv
// Joined binary-op pipeline with bubble collapsing.
// Result enters stage 0, leaves from stage LATENCY-1.
module leaf_binop_pipe #(
  parameter int STREAMW = 32,
  parameter int LATENCY = 3,
  parameter int OPCODE  = 1
) (
  input logic            clk,
  input logic            rst,
  leaf_binop_pipe_if.slave bus
);

  logic [STREAMW-1:0] data [LATENCY];
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] can;
  logic [STREAMW-1:0] res;
  logic               fire;
  logic               xfer;
  logic [3:0]         occ;

  // Operation selected at elaboration; wraps modulo 2^STREAMW.
  always_comb begin
    res = '0;
    unique case (1'b1)
      (OPCODE == 0): res = bus.in1 + bus.in2;
      (OPCODE == 1): res = bus.in1 - bus.in2;
      (OPCODE == 2): res = bus.in1 * bus.in2;
      default:       res = bus.in1 + bus.in2;
    endcase
  end

  // A stage may load when some stage at or past it is empty,
  // or the output is draining this cycle.
  always_comb begin : can_b
    logic full;
    can = '0;
    for (int k = 0; k < LATENCY; k++) begin
      full = 1'b1;
      for (int j = k; j < LATENCY; j++) begin
        full = full & vld[j];
      end
      can[k] = bus.oready | ~full;
    end
  end

  assign xfer = vld[LATENCY-1] & bus.oready;
  assign fire = ~rst & bus.ivalid_in1
              & bus.ivalid_in2 & can[0];

  assign bus.iready_in1 = fire;
  assign bus.iready_in2 = fire;
  assign bus.out1       = data[LATENCY-1];
  assign bus.ovalid     = vld[LATENCY-1];
  assign bus.occupancy  = occ;

  // Stage registers: load from upstream when allowed, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        data[k] <= '0;
      end
    end else begin
      if (can[0]) begin
        vld[0] <= fire;
        if (fire) data[0] <= res;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (can[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) data[k] <= data[k-1];
        end
      end
    end
  end

  // Count of valid results held in the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case ({fire, xfer})
        2'b10:   occ <= occ + 4'd1;
        2'b01:   occ <= occ - 4'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_binop_pipe.sv
// Directed and random checks of leaf_binop_pipe.
// Scoreboard queues per instance, compared on output transfer.
`define MON(B, Q, I, OP, W, TAG) \
  always @(negedge clk) begin \
    logic [63:0] e; \
    if (rst) begin \
      Q.delete(); \
      sv[I] = 1'b0; \
    end else begin \
      if (sv[I]) begin \
        n++; \
        assert (B.ovalid === 1'b1 && 64'(B.out1) === sd[I]) \
        else begin \
          errs++; \
          $error("FAIL %s_stall obs=%0h exp=%0h", TAG, 64'(B.out1), sd[I]); \
        end \
      end \
      if (B.ovalid && B.oready) begin \
        n++; \
        e = (Q.size() > 0) ? Q[0] : 64'hDEAD_DEAD_DEAD_DEAD; \
        assert (Q.size() > 0 && 64'(B.out1) === e) \
        else begin \
          errs++; \
          $error("FAIL %s_sb obs=%0h exp=%0h", TAG, 64'(B.out1), e); \
        end \
        if (Q.size() > 0) void'(Q.pop_front()); \
      end \
      sv[I] = B.ovalid && !B.oready; \
      sd[I] = 64'(B.out1); \
      if (B.ivalid_in1 && B.ivalid_in2 && B.iready_in1) \
        Q.push_back(model(OP, W, 64'(B.in1), 64'(B.in2))); \
    end \
  end

module tb_leaf_binop_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  leaf_binop_pipe_if #(.STREAMW(32)) b0 ();
  leaf_binop_pipe_if #(.STREAMW(8))  b1 ();
  leaf_binop_pipe_if #(.STREAMW(16)) b2 ();

  leaf_binop_pipe #(.STREAMW(32), .LATENCY(3), .OPCODE(1))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  leaf_binop_pipe #(.STREAMW(8), .LATENCY(1), .OPCODE(2))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  leaf_binop_pipe #(.STREAMW(16), .LATENCY(8), .OPCODE(0))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n = 0;
  int errs = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic        sv[3];
  logic [63:0] sd[3];

  function automatic logic [63:0] model(
    int op, int w, logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      default: r = a * b;
    endcase
    return r & ((64'h1 << w) - 64'h1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(logic v, logic [31:0] a, logic [31:0] b);
    b0.ivalid_in1 = v;
    b0.ivalid_in2 = v;
    b0.in1 = a;
    b0.in2 = b;
  endtask

  `MON(b0, q0, 0, 1, 32, "u0")
  `MON(b1, q1, 1, 2, 8, "u1")
  `MON(b2, q2, 2, 0, 16, "u2")

  initial begin
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    logic [31:0] ea[3];
    int idx;
    pa = '{32'd10, 32'd0, 32'd5};
    pb = '{32'd3, 32'd1, 32'd5};
    ea = '{32'd7, 32'hFFFF_FFFF, 32'd0};

    rst = 1'b1;
    put0(1'b1, 32'd1, 32'd1);
    b0.oready = 1'b1;
    b1.ivalid_in1 = 1'b0; b1.ivalid_in2 = 1'b0;
    b1.in1 = '0; b1.in2 = '0; b1.oready = 1'b0;
    b2.ivalid_in1 = 1'b0; b2.ivalid_in2 = 1'b0;
    b2.in1 = '0; b2.in2 = '0; b2.oready = 1'b0;
    #12;
    chk("rst_ovalid", b0.ovalid, 0);
    chk("rst_iready1", b0.iready_in1, 0);
    chk("rst_iready2", b0.iready_in2, 0);
    chk("rst_occ", b0.occupancy, 0);
    chk("rst_out1", b0.out1, 0);
    put0(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // latency and sequence with oready high
    b0.oready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        put0(1'b1, pa[i], pb[i]);
        #1 chk("join_rdy", b0.iready_in1, 1);
      end else begin
        put0(1'b0, 32'd0, 32'd0);
      end
      tick();
      chk("lat_ovalid", b0.ovalid, (i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) chk("lat_out1", b0.out1, ea[i-2]);
    end

    // fill while stalled, then drain with no dead cycle
    b0.oready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      put0(1'b1, 32'(100 + idx), 32'(idx * 7));
      #1 if (b0.iready_in1) idx++;
      tick();
    end
    chk("full_accepted", 64'(idx), 3);
    chk("full_occ", b0.occupancy, 3);
    chk("full_iready1", b0.iready_in1, 0);
    chk("full_iready2", b0.iready_in2, 0);
    b0.oready = 1'b1;
    #1;
    chk("nodead_iready", b0.iready_in1, 1);
    chk("nodead_ovalid", b0.ovalid, 1);
    for (int c = 0; c < 20; c++) begin
      if (idx < 5) put0(1'b1, 32'(100 + idx), 32'(idx * 7));
      else put0(1'b0, 32'd0, 32'd0);
      #1 if (idx < 5 && b0.iready_in1) idx++;
      tick();
    end
    chk("drain_accepted", 64'(idx), 5);
    chk("drain_occ", b0.occupancy, 0);
    chk("drain_q", 64'(q0.size()), 0);

    // one operand alone never consumed
    b0.oready = 1'b0;
    b0.ivalid_in1 = 1'b1; b0.ivalid_in2 = 1'b0;
    b0.in1 = 32'd5; b0.in2 = 32'd2;
    for (int c = 0; c < 4; c++) begin
      #1 chk("solo_rdy1", b0.iready_in1, 0);
      tick();
    end
    chk("solo_occ", b0.occupancy, 0);
    b0.ivalid_in2 = 1'b1;
    #1 chk("solo_join", b0.iready_in1, 1);
    tick();
    put0(1'b0, 32'd0, 32'd0);
    #1 chk("solo_occ1", b0.occupancy, 1);
    b0.oready = 1'b1;
    repeat (4) tick();
    chk("solo_drain", b0.occupancy, 0);

    // async reset mid-stream with two results held
    b0.oready = 1'b0;
    put0(1'b1, 32'd50, 32'd8);
    tick();
    put0(1'b1, 32'd60, 32'd9);
    tick();
    put0(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("pre_rst_occ", b0.occupancy, 2);
    chk("pre_rst_ovalid", b0.ovalid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_ovalid", b0.ovalid, 0);
    chk("arst_occ", b0.occupancy, 0);
    tick();
    put0(1'b1, 32'd7, 32'd2);
    b0.oready = 1'b1;
    #1 chk("arst_iready", b0.iready_in1, 0);
    #1 rst = 1'b0;
    #1 chk("post_rst_fire", b0.iready_in1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      put0(1'b0, 32'd0, 32'd0);
      chk("post_rst_ovalid", b0.ovalid, (i == 2));
      if (i == 2) chk("post_rst_out1", b0.out1, 5);
    end
    tick();

    // narrow multiply wraps
    b1.oready = 1'b1;
    b1.in1 = 8'd200; b1.in2 = 8'd3;
    b1.ivalid_in1 = 1'b1; b1.ivalid_in2 = 1'b1;
    tick();
    b1.ivalid_in1 = 1'b0; b1.ivalid_in2 = 1'b0;
    chk("mul8_ovalid", b1.ovalid, 1);
    chk("mul8_out1", b1.out1, 64'h58);
    tick();

    // random valid/ready on all three instances
    for (int c = 0; c < 2000; c++) begin
      put0($urandom_range(0, 3) != 0, $urandom, $urandom);
      b0.ivalid_in2 = $urandom_range(0, 3) != 0;
      b0.oready = $urandom_range(0, 3) != 0;
      b1.ivalid_in1 = $urandom_range(0, 3) != 0;
      b1.ivalid_in2 = $urandom_range(0, 3) != 0;
      b1.in1 = 8'($urandom); b1.in2 = 8'($urandom);
      b1.oready = $urandom_range(0, 2) != 0;
      b2.ivalid_in1 = $urandom_range(0, 3) != 0;
      b2.ivalid_in2 = $urandom_range(0, 3) != 0;
      b2.in1 = 16'($urandom); b2.in2 = 16'($urandom);
      b2.oready = $urandom_range(0, 2) != 0;
      tick();
    end
    put0(1'b0, 32'd0, 32'd0);
    b0.oready = 1'b1;
    b1.ivalid_in1 = 1'b0; b1.ivalid_in2 = 1'b0; b1.oready = 1'b1;
    b2.ivalid_in1 = 1'b0; b2.ivalid_in2 = 1'b0; b2.oready = 1'b1;
    repeat (20) tick();
    chk("rnd_q0", 64'(q0.size()), 0);
    chk("rnd_q1", 64'(q1.size()), 0);
    chk("rnd_q2", 64'(q2.size()), 0);
    chk("rnd_occ2", b2.occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end

endmodule
